riscv_lsu_multi: RTL and testbench

Parametrised load/store unit for the multicycle RISC-V core. It replaces the core's zero-wait, word-only memory port with a valid/ready bus master. It adds byte/halfword/word (and doubleword at WIDTH=64) accesses, sign/zero extension, byte enables, misalignment and illegal-funct3 detection, and a bus timeout. It sits between the core controller's memory-state FSM and the memory/interconnect; the core holds its memory state until `done`.

---
 rtl/riscv_lsu_multi.sv | 183 ++++++++++++++++++
 tb/tb_riscv_lsu_multi.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu_multi.sv
// Load/store unit for the multicycle RISC-V core: a valid/ready bus master with
// sub-word accesses, lane placement, load extension, legality checks and a bus timeout.
module riscv_lsu_multi #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [WIDTH-1:0]      rdata,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [WIDTH/8-1:0]    bus_be,
  output logic [WIDTH-1:0]      bus_wdata,
  input  logic [WIDTH-1:0]      bus_rdata
);
  localparam int NB = WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic            err_q;
  logic            ld_p0;
  logic [2:0]      f3_p0;
  logic [OW-1:0]   off_p0;
  logic [OW-1:0]   off_in;
  logic            bad_in;
  logic            hs;
  logic            tmo;

  // Legal size/sign codes; doubleword and lwu exist only on a 64-bit bus.
  function automatic logic f3_legal(input logic st, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b011:                 ok = (WIDTH == 64);
      3'b100, 3'b101:         ok = !st;
      3'b110:                 ok = !st && (WIDTH == 64);
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Any offset bit below the access size marks a misaligned access.
  function automatic logic misaligned(input logic [2:0] f3, input logic [OW-1:0] off);
    logic [3:0] lo;
    logic [3:0] mask;
    lo   = 4'(off);
    mask = (4'd1 << f3[1:0]) - 4'd1;
    return |(lo & mask);
  endfunction

  // Contiguous enables of the access size, starting at the byte offset.
  function automatic logic [NB-1:0] byte_en(input logic [2:0] f3, input logic [OW-1:0] off);
    logic [15:0] ones;
    ones = (16'd1 << (5'd1 << f3[1:0])) - 16'd1;
    ones = ones << off;
    return ones[NB-1:0];
  endfunction

  // Low access-size bytes of the store data copied into every lane group.
  function automatic logic [WIDTH-1:0] lane_repl(input logic [2:0] f3, input logic [WIDTH-1:0] wd);
    logic [WIDTH-1:0] r;
    logic [2:0]       m;
    m = 3'((4'd1 << f3[1:0]) - 4'd1);
    r = '0;
    for (int i = 0; i < NB; i++)
      r[8*i +: 8] = wd[8*(i & int'(m)) +: 8];
    return r;
  endfunction

  // Right-align the addressed bytes, then sign- or zero-extend by shifting up and back down.
  function automatic logic [WIDTH-1:0] load_ext(input logic [2:0] f3, input logic [OW-1:0] off,
                                                input logic [WIDTH-1:0] rd);
    logic [WIDTH-1:0]        sh;
    logic signed [WIDTH-1:0] ss;
    int                      shamt;
    sh    = rd >> {off, 3'b000};
    shamt = WIDTH - (8 << f3[1:0]);
    if (shamt < 0)
      shamt = 0;
    sh = sh << shamt;
    ss = $signed(sh) >>> shamt;
    return f3[2] ? (sh >> shamt) : $unsigned(ss);
  endfunction

  assign off_in = addr[OW-1:0];
  assign bad_in = !f3_legal(we, funct3) || misaligned(funct3, off_in);
  assign hs     = (state == BUS) && bus_ready;
  assign tmo    = (state == BUS) && !bus_ready && (cnt == CW'(TIMEOUT - 1));

  // Next-state and status outputs; handshake takes priority over timeout.
  always_comb begin
    state_nx  = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    err       = (state == DONE) && err_q;
    bus_valid = (state == BUS);
    case (state)
      IDLE:    if (req) state_nx = bad_in ? DONE : BUS;
      BUS:     if (hs || tmo) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Request capture (p0): fields needed to place and extend the returned load data.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      ld_p0  <= !we;
      f3_p0  <= funct3;
      off_p0 <= off_in;
    end
  end

  // Bus request registers, timeout counter and access result.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      err_q     <= 1'b0;
      rdata     <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req) begin
            err_q <= bad_in;
            if (bad_in) begin
              rdata <= '0;
            end else begin
              bus_we    <= we;
              bus_addr  <= addr & ~ADDR_WIDTH'(NB - 1);
              bus_be    <= byte_en(funct3, off_in);
              bus_wdata <= lane_repl(funct3, wdata);
            end
          end
        end
        BUS: begin
          if (hs) begin
            err_q <= 1'b0;
            rdata <= ld_p0 ? load_ext(f3_p0, off_p0, bus_rdata) : '0;
          end else begin
            cnt <= cnt + 1'b1;
            if (tmo) begin
              err_q <= 1'b1;
              rdata <= '0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu_multi.sv
// Bench for riscv_lsu_multi: a 32-bit and a 64-bit instance share stimulus; a timeline
// model of each access predicts every output cycle by cycle.
`timescale 1ns/1ps
module tb_riscv_lsu_multi;
  localparam int TO32 = 4;
  localparam int TO64 = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        bus_ready = 1'b0;
  logic        s_sel = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [63:0] wdata = 64'd0;
  logic [63:0] bus_rdata = 64'd0;

  logic        a_req, a_busy, a_done, a_err, a_valid, a_we;
  logic [31:0] a_rdata, a_addr, a_wdata;
  logic [3:0]  a_be;
  logic        b_req, b_busy, b_done, b_err, b_valid, b_we;
  logic [63:0] b_rdata, b_wdata;
  logic [31:0] b_addr;
  logic [7:0]  b_be;

  assign a_req = req & ~s_sel;
  assign b_req = req & s_sel;

  riscv_lsu_multi #(.WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO32)) dut32 (
    .clk(clk), .reset(reset), .req(a_req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata[31:0]), .busy(a_busy), .done(a_done), .err(a_err), .rdata(a_rdata),
    .bus_valid(a_valid), .bus_ready(bus_ready), .bus_we(a_we), .bus_addr(a_addr),
    .bus_be(a_be), .bus_wdata(a_wdata), .bus_rdata(bus_rdata[31:0]));

  riscv_lsu_multi #(.WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT(TO64)) dut64 (
    .clk(clk), .reset(reset), .req(b_req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .busy(b_busy), .done(b_done), .err(b_err), .rdata(b_rdata),
    .bus_valid(b_valid), .bus_ready(bus_ready), .bus_we(b_we), .bus_addr(b_addr),
    .bus_be(b_be), .bus_wdata(b_wdata), .bus_rdata(bus_rdata));

  // Outputs of the selected instance, zero-extended to 64-bit width.
  logic        o_busy, o_done, o_err, o_valid, o_we;
  logic [63:0] o_rdata, o_wdata;
  logic [31:0] o_addr;
  logic [7:0]  o_be;
  assign o_busy  = s_sel ? b_busy  : a_busy;
  assign o_done  = s_sel ? b_done  : a_done;
  assign o_err   = s_sel ? b_err   : a_err;
  assign o_valid = s_sel ? b_valid : a_valid;
  assign o_we    = s_sel ? b_we    : a_we;
  assign o_addr  = s_sel ? b_addr  : a_addr;
  assign o_be    = s_sel ? b_be    : {4'h0, a_be};
  assign o_rdata = s_sel ? b_rdata : {32'h0, a_rdata};
  assign o_wdata = s_sel ? b_wdata : {32'h0, a_wdata};

  always #5 clk = ~clk;

  // Expected outputs for the current cycle.
  logic        e_chk = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0, e_valid = 1'b0;
  logic        e_bus0 = 1'b0, e_we = 1'b0;
  logic [31:0] e_addr = 32'd0;
  logic [7:0]  e_be = 8'd0;
  logic [63:0] e_wdata = 64'd0;
  logic [63:0] exp_rdata [2];

  int nvec = 0;
  int nerr = 0;

  // Observations used by the literal checks.
  logic [31:0] last_addr = 32'd0;
  logic [7:0]  last_be = 8'd0;
  logic [63:0] last_wdata = 64'd0, last_rdata = 64'd0;
  logic        last_err = 1'b0;
  int          vcnt = 0, last_vcnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Compare every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (e_chk) begin
      chk1("busy", o_busy, e_busy);
      chk1("done", o_done, e_done);
      chk1("bus_valid", o_valid, e_valid);
      if (e_done) chk1("err", o_err, e_err);
      chk("rdata", o_rdata, exp_rdata[s_sel]);
      if (e_valid) begin
        chk1("bus_we", o_we, e_we);
        chk("bus_addr", 64'(o_addr), 64'(e_addr));
        chk("bus_be", 64'(o_be), 64'(e_be));
        chk("bus_wdata", o_wdata, e_wdata);
      end
      if (e_bus0) begin
        chk1("reset bus_we", o_we, 1'b0);
        chk("reset bus_addr", 64'(o_addr), 64'd0);
        chk("reset bus_be", 64'(o_be), 64'd0);
        chk("reset bus_wdata", o_wdata, 64'd0);
      end
    end
    if (o_valid) begin
      vcnt++;
      last_addr  = o_addr;
      last_be    = o_be;
      last_wdata = o_wdata;
    end
    if (o_done) begin
      last_rdata = o_rdata;
      last_err   = o_err;
      last_vcnt  = vcnt;
    end
    if (!o_valid) vcnt = 0;
  end

  // ---------------- behavioural model ----------------
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input int w, input bit st, input logic [2:0] f3);
    int c;
    c = int'(f3);
    if (st) return (c <= 2) || (w == 64 && c == 3);
    return c == 0 || c == 1 || c == 2 || c == 4 || c == 5 || (w == 64 && (c == 3 || c == 6));
  endfunction

  function automatic logic [7:0] m_be(input int w, input int off, input int sz);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < w / 8; i++)
      r[i] = (i >= off) && (i < off + sz);
    return r;
  endfunction

  function automatic logic [63:0] m_wrep(input int w, input int sz, input logic [63:0] wd);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < w / 8; i++)
      r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_ext(input int w, input logic [2:0] f3, input int off,
                                        input logic [63:0] rd);
    logic [63:0] r;
    bit          neg;
    int          sz;
    sz = m_size(f3);
    r  = 64'd0;
    for (int k = 0; k < sz; k++)
      r[8*k +: 8] = rd[8*(off + k) +: 8];
    neg = !f3[2] && rd[8*(off + sz) - 1];
    for (int k = sz; k < w / 8; k++)
      r[8*k +: 8] = neg ? 8'hFF : 8'h00;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_ctl(input bit b, input bit d, input bit e, input bit v);
    e_busy  = b;
    e_done  = d;
    e_err   = e;
    e_valid = v;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    exp_ctl(0, 0, 0, 0);
    repeat (n) step();
  endtask

  // One access: nwait cycles of ready low before ready high; rbusy pulses req while busy.
  task automatic run_txn(input bit sel, input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [63:0] wd, input logic [63:0] rd, input int nwait,
                         input bit rbusy);
    int w, to, off, sz;
    bit bad, hs;
    w   = sel ? 64 : 32;
    to  = sel ? TO64 : TO32;
    sz  = m_size(f3);
    off = int'(a[2:0]) % (w / 8);
    bad = !m_legal(w, st, f3) || (int'(a[2:0]) % sz != 0);
    hs  = 0;
    s_sel = sel; req = 1'b1; we = st; funct3 = f3; addr = a; wdata = wd;
    bus_ready = 1'b0; bus_rdata = {$urandom, $urandom};
    exp_ctl(0, 0, 0, 0);
    step();
    req = 1'b0; we = 1'($urandom); funct3 = 3'($urandom); addr = $urandom;
    wdata = {$urandom, $urandom};
    if (bad) begin
      exp_ctl(1, 1, 1, 0);
      exp_rdata[sel] = 64'd0;
      req = rbusy;
      step();
    end else begin
      e_we    = st;
      e_addr  = a - 32'(off);
      e_be    = m_be(w, off, sz);
      e_wdata = m_wrep(w, sz, wd);
      for (int j = 1; j <= to; j++) begin
        bus_ready = (j > nwait);
        bus_rdata = bus_ready ? rd : {$urandom, $urandom};
        req = rbusy && ($urandom_range(1, 0) == 1);
        exp_ctl(1, 0, 0, 1);
        step();
        if (j > nwait) begin
          hs = 1;
          break;
        end
      end
      bus_ready = 1'($urandom);
      req = rbusy;
      exp_ctl(1, 1, !hs, 0);
      exp_rdata[sel] = (hs && !st) ? m_ext(w, f3, off, rd) : 64'd0;
      step();
    end
    req = 1'b0;
    bus_ready = 1'b0;
  endtask

  // Aligned load aborted by reset in its nbus-th bus cycle.
  task automatic abort_txn(input bit sel, input int nbus);
    int w;
    w = sel ? 64 : 32;
    s_sel = sel; req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h400;
    wdata = {$urandom, $urandom}; bus_ready = 1'b0;
    e_we = 1'b0; e_addr = 32'h400; e_be = m_be(w, 0, 4); e_wdata = m_wrep(w, 4, wdata);
    exp_ctl(0, 0, 0, 0);
    step();
    req = 1'b0;
    for (int j = 1; j <= nbus; j++) begin
      reset = (j == nbus);
      exp_ctl(1, 0, 0, 1);
      step();
    end
    reset = 1'b0;
    exp_rdata[0] = 64'd0;
    exp_rdata[1] = 64'd0;
    exp_ctl(0, 0, 0, 0);
    e_bus0 = 1'b1;
    step();
    e_bus0 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d vectors, %0d miscompares", nvec, nerr);
    $fatal(1);
  end

  initial begin
    bit          sel, st, rb;
    logic [2:0]  f3;
    logic [31:0] a;
    int          r, nw, to;
    exp_rdata[0] = 64'd0;
    exp_rdata[1] = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    e_chk = 1'b1; e_bus0 = 1'b1; exp_ctl(0, 0, 0, 0);
    s_sel = 1'b0; step();
    s_sel = 1'b1; step();
    reset = 1'b0; e_bus0 = 1'b0; s_sel = 1'b0;
    idle(2);

    // lb, zero-wait
    run_txn(0, 0, 3'b000, 32'h1003, 64'd0, 64'h80FF_1234, 0, 0);
    chk("lb bus_addr", 64'(last_addr), 64'h1000);
    chk("lb bus_be", 64'(last_be), 64'h8);
    chk("lb rdata", last_rdata, 64'hFFFF_FF80);
    idle(1);
    // sh with three wait states
    run_txn(0, 1, 3'b001, 32'h2002, 64'hDEAD_BEEF, 64'd0, 3, 0);
    chk("sh bus_be", 64'(last_be), 64'hC);
    chk("sh bus_wdata", last_wdata, 64'hBEEF_BEEF);
    chk1("sh err", last_err, 1'b0);
    chk("sh valid cycles", 64'(last_vcnt), 64'd4);
    idle(1);
    // misaligned lw and illegal funct3
    run_txn(0, 0, 3'b010, 32'h3001, 64'd0, 64'hFFFF_FFFF, 0, 0);
    chk1("misaligned err", last_err, 1'b1);
    chk("misaligned valid cycles", 64'(last_vcnt), 64'd0);
    run_txn(0, 0, 3'b011, 32'h3000, 64'd0, 64'hFFFF_FFFF, 0, 0);
    chk1("illegal f3 err", last_err, 1'b1);
    idle(1);
    // timeout, then ready on the last permitted cycle
    run_txn(0, 0, 3'b010, 32'h40, 64'd0, 64'h1234_5678, 10, 0);
    chk1("timeout err", last_err, 1'b1);
    chk("timeout valid cycles", 64'(last_vcnt), 64'd4);
    chk("timeout rdata", last_rdata, 64'd0);
    run_txn(0, 0, 3'b010, 32'h40, 64'd0, 64'h1234_5678, 3, 0);
    chk1("late ready err", last_err, 1'b0);
    chk("late ready rdata", last_rdata, 64'h1234_5678);
    idle(1);
    // 64-bit lwu
    run_txn(1, 0, 3'b110, 32'h14, 64'd0, 64'h8765_4321_0000_0000, 0, 0);
    chk("lwu bus_be", 64'(last_be), 64'hF0);
    chk("lwu rdata", last_rdata, 64'h0000_0000_8765_4321);
    idle(1);
    // reset mid-access, then back-to-back lw/sw with req pulsed while busy
    abort_txn(0, 2);
    abort_txn(1, 1);
    run_txn(0, 0, 3'b010, 32'h80, 64'd0, 64'hCAFE_F00D, 1, 1);
    run_txn(0, 1, 3'b010, 32'h84, 64'h1357_9BDF, 64'd0, 0, 1);
    chk("b2b sw bus_wdata", last_wdata, 64'h1357_9BDF);
    chk("b2b lw rdata held", last_rdata, 64'd0);

    // randomized accesses
    repeat (400) begin
      sel = 1'($urandom);
      st  = 1'($urandom);
      f3  = 3'($urandom);
      rb  = 1'($urandom);
      to  = sel ? TO64 : TO32;
      a   = $urandom;
      if ($urandom_range(3, 0) != 0)
        a = a & ~(32'(m_size(f3)) - 32'd1);
      r = $urandom_range(9, 0);
      if (r < 6)      nw = r % 3;
      else if (r < 8) nw = to - 1;
      else            nw = to + (r % 3);
      if ($urandom_range(24, 0) == 0)
        abort_txn(sel, 1 + $urandom_range(1, 0));
      run_txn(sel, st, f3, a, {$urandom, $urandom}, {$urandom, $urandom}, nw, rb);
      idle($urandom_range(2, 0));
    end

    idle(2);
    e_chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
